// File: rtl/rst_seq_ctrl.sv
// Central reset sequencer: holds all domains in reset, then releases them in index order.
// Registered outputs; a request in any state restarts the hold window; no backpressure.
module rst_seq_ctrl #(
  parameter int NUM_SRC     = 3,
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     rst_req_i,
  input  logic                   cause_clr_i,
  output logic [NUM_DOMAINS-1:0] domain_rst_o,
  output logic                   seq_busy_o,
  output logic                   seq_done_o,
  output logic [NUM_SRC:0]       rst_cause_o
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_IDLE
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_d;
  logic                   busy_d;
  logic                   done_d;
  logic [NUM_SRC:0]       cause_d;
  logic                   any_req;

  assign any_req = |rst_req_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = domain_rst_o;
    done_d  = 1'b0;

    case (state_q)
      S_HOLD: begin
        dom_d = '1;
        if (any_req) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d    = '0;
          dom_d[0] = 1'b0;
          if (NUM_DOMAINS == 1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RELEASE;
            idx_d   = IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        if (any_req) begin
          // Abort: the partially released sequence never reports done.
          state_d = S_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          dom_d   = '1;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d        = '0;
          dom_d[idx_q] = 1'b0;
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        dom_d = '0;
        if (any_req) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          dom_d   = '1;
        end
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // An active request outranks a simultaneous clear.
  always_comb begin
    cause_d = cause_clr_i ? '0 : rst_cause_o;
    cause_d = cause_d | {rst_req_i, 1'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_HOLD;
      cnt_q        <= '0;
      idx_q        <= '0;
      domain_rst_o <= '1;
      seq_busy_o   <= 1'b1;
      seq_done_o   <= 1'b0;
      rst_cause_o  <= {{NUM_SRC{1'b0}}, 1'b1};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      domain_rst_o <= dom_d;
      seq_busy_o   <= busy_d;
      seq_done_o   <= done_d;
      rst_cause_o  <= cause_d;
    end
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Central reset sequencer for the SoC.
- Collects reset requests from several sources: the software-controlled reset output of the AXI reset CSR block, the watchdog, and the external button.
- Holds every reset domain asserted for a minimum time, then releases the domains one by one in a fixed order with a programmable gap between them.
- Records which source caused the last reset, so boot firmware can read it.

Parameters:
- NUM_SRC, 3, number of reset request inputs.
- NUM_DOMAINS, 3, number of sequenced reset outputs. Index 0 is released first.
- HOLD_CYCLES, 16, minimum number of cycles all domains stay asserted after the last active request. Must be at least 1.
- STAGE_GAP, 8, cycles between the release of domain i-1 and domain i. Must be at least 1.
- CNT_W, 8, counter width. Must satisfy 2^CNT_W > max(HOLD_CYCLES, STAGE_GAP).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rst_req_i  in  NUM_SRC  active-high, level-sensitive reset requests, already synchronous to clk.
- cause_clr_i  in  1  single-cycle pulse that clears rst_cause_o.
- domain_rst_o  out  NUM_DOMAINS  active-high reset per domain, registered.
- seq_busy_o  out  1  high while the FSM is in HOLD or RELEASE.
- seq_done_o  out  1  one-cycle pulse when the last domain is released.
- rst_cause_o  out  NUM_SRC+1  sticky cause flags. Bit 0 is power-on (POR); bit k+1 is rst_req_i[k].

Behaviour:
- **Reset (rst low), asynchronous:**
  - domain_rst_o = all 1s, seq_busy_o = 1, seq_done_o = 0.
  - rst_cause_o = 'b1 (POR only).
  - state = HOLD, cnt = 0, idx = 0.
- **FSM states: HOLD, RELEASE, IDLE.** All outputs are registered.
- **HOLD:**
  - All domains are asserted.
  - If any rst_req_i bit is high, cnt is forced to 0. A request held high therefore extends HOLD indefinitely.
  - Otherwise cnt increments.
  - When cnt == HOLD_CYCLES-1 and no request is active, the FSM moves to RELEASE with idx = 1 and cnt = 0, and domain_rst_o[0] clears on that same edge.
  - With NUM_DOMAINS == 1 the FSM goes straight to IDLE instead.
- **RELEASE:**
  - cnt increments every cycle.
  - When cnt == STAGE_GAP-1, domain_rst_o[idx] clears, cnt returns to 0, and idx increments.
  - Clearing domain NUM_DOMAINS-1 moves the FSM to IDLE and sets seq_done_o = 1 for exactly one cycle, the same cycle that domain goes low.
  - Domains already released stay low; domains not yet released stay high.
- **IDLE:** domain_rst_o = 0, seq_busy_o = 0.
- **Request in IDLE or RELEASE:** any rst_req_i bit high at cycle t means:
  - at t+1, domain_rst_o = all 1s, state = HOLD, cnt = 0, idx = 0;
  - any release in progress is aborted;
  - no seq_done_o pulse is issued for the aborted sequence.
- **Release timing after the last request drops:** with the request last high at cycle t, domain 0 releases at t+1+HOLD_CYCLES and domain i at t+1+HOLD_CYCLES+i*STAGE_GAP.
- **Cause capture:**
  - Every cycle in which rst_req_i[k] is high sets rst_cause_o[k+1].
  - Flags are sticky until cause_clr_i.
  - cause_clr_i zeroes all bits, including POR.
  - If cause_clr_i and a request occur in the same cycle, the request wins: only the bits of the active requests remain set.
- **Simultaneous requests:** there is no priority between sources; every active source bit is recorded.
- **seq_done_o** is never high while seq_busy_o is high in the same cycle.
- **Reset mid-sequence:** an asynchronous assertion of rst returns all state to the reset values immediately. After rst deasserts, the full power-on sequence runs.

Test Plan:
- **POR, defaults, no requests.** rst deasserted at edge 0 → domain_rst_o[0] low at cycle 16, [1] at 24, [2] at 32; seq_done_o high at cycle 32 only; seq_busy_o low from cycle 32; rst_cause_o = 4'b0001.
- **Clear, then request in IDLE.** cause_clr_i pulse, then rst_req_i = 3'b010 for 1 cycle at cycle t → domain_rst_o = 3'b111 at t+1; domain 0 released at t+17, domain 2 at t+33; rst_cause_o = 4'b0100.
- **Abort during RELEASE.** rst_req_i[0] pulsed 4 cycles after domain 0 releases → all domains re-asserted on the next cycle; no seq_done_o for the aborted run; a fresh 16/8/8 sequence follows; bit 1 of the cause is set.
- **Held request.** rst_req_i[2] high for 50 cycles → domains stay asserted throughout; domain 0 is released exactly 17 cycles after the request drops.
- **Clear/request collision.** cause_clr_i and rst_req_i = 3'b101 in the same cycle while rst_cause_o = 4'b0011 → rst_cause_o = 4'b1010 next cycle.
- **Asynchronous reset mid-sequence.** rst pulled low while in RELEASE with idx = 1, between clock edges → domain_rst_o = 3'b111 immediately (no clock edge needed); rst_cause_o = 4'b0001; the POR sequence repeats after release.
